// File: rtl/handshake_link.sv
// Self-contained valid/ready link: buffered master, LFSR-backpressured slave, rx beat reporting.
// Latency: put to bus valid one edge, bus accept to rx_valid one edge.
// Backpressure: put_ready drops when the master buffer is full; bus ready is constant or LFSR-driven.

// Generic synchronous FIFO with registered storage and head-of-queue read data.
// Latency: a write becomes visible at rd_dat/rd_vld after the next edge.
// Backpressure: wr_rdy low while full; a write that arrives while full is ignored.
module handshake_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Link top: put port feeds the master FIFO, bus handshake to the slave, slave reports beats.
// Latency: one edge put->valid, one edge valid&&ready->rx_valid; 1 beat/cycle with ready high.
// Backpressure: ready low holds valid/data stable; FIFO full drops put_ready.
module handshake_link #(
    parameter int          DATA_BITS    = 8,
    parameter bit          ALWAYS_READY = 1'b1,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 put_valid,
    input  logic [DATA_BITS-1:0] put_data,
    output logic                 put_ready,
    output logic                 valid,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic [15:0]          beat_count
);
    logic live;
    logic xfer;

    handshake_fifo #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (put_valid),
        .wr_rdy (put_ready),
        .wr_dat (put_data),
        .rd_vld (valid),
        .rd_rdy (ready),
        .rd_dat (data)
    );

    // live keeps ready low during reset and the partial cycle after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    generate
        if (ALWAYS_READY) begin : g_const_ready
            assign ready = live;
        end else begin : g_lfsr_ready
            logic [15:0] lfsr;
            logic [1:0]  stall_cnt;
            logic        fb;

            // Fibonacci taps 16,14,13,11 in right-shift form
            assign fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
            assign ready = live && (lfsr[0] || (stall_cnt == 2'd3));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lfsr      <= LFSR_SEED;
                    stall_cnt <= 2'd0;
                end else if (live) begin
                    lfsr      <= {fb, lfsr[15:1]};
                    stall_cnt <= ready ? 2'd0 : stall_cnt + 2'd1;
                end
            end
        end
    endgenerate

    assign xfer = valid && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            beat_count <= 16'd0;
        end else begin
            rx_valid <= xfer;
            if (xfer) begin
                rx_data    <= data;
                beat_count <= beat_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_handshake_link.sv
// Bench for handshake_link: lane a always-ready (vector table + wrap), lane b LFSR ready (queue model).
module tb_handshake_link;
    localparam int          DEPTH = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk;
    logic rst;

    logic       a_put_valid, a_put_ready, a_valid, a_ready, a_rx_valid;
    logic [7:0] a_put_data, a_data, a_rx_data;
    logic [15:0] a_beat_count;
    logic       b_put_valid, b_put_ready, b_valid, b_ready, b_rx_valid;
    logic [7:0] b_put_data, b_data, b_rx_data;
    logic [15:0] b_beat_count;

    handshake_link #(.DATA_BITS(8), .ALWAYS_READY(1'b1), .FIFO_DEPTH(DEPTH), .LFSR_SEED(SEED)) dut_a (
        .clk(clk), .rst(rst), .put_valid(a_put_valid), .put_data(a_put_data), .put_ready(a_put_ready),
        .valid(a_valid), .ready(a_ready), .data(a_data), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
        .beat_count(a_beat_count));

    handshake_link #(.DATA_BITS(8), .ALWAYS_READY(1'b0), .FIFO_DEPTH(DEPTH), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .rst(rst), .put_valid(b_put_valid), .put_data(b_put_data), .put_ready(b_put_ready),
        .valid(b_valid), .ready(b_ready), .data(b_data), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .beat_count(b_beat_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane b reference: beat queue plus spec-level ready rule
    logic [7:0]  mq[$];
    logic [7:0]  obs[$];
    logic [7:0]  eq[$];
    bit          m_live;
    logic [15:0] m_lfsr;
    int          m_stall;
    bit          m_rxv;
    logic [7:0]  m_rxd;
    logic [15:0] m_cnt;
    bit          prev_vld, prev_rdy;
    logic [7:0]  prev_dat;
    int          low_run;
    bit          saw_full;

    task automatic m_reset();
        mq.delete();
        m_live = 0; m_lfsr = SEED; m_stall = 0;
        m_rxv = 0; m_rxd = 8'h00; m_cnt = 16'd0;
        prev_vld = 0; prev_rdy = 0; prev_dat = 8'h00; low_run = 0;
    endtask

    function automatic bit m_ready();
        if (!m_live) return 1'b0;
        return m_lfsr[0] || (m_stall == 3);
    endfunction

    // Called at a negedge: check lane b, drive both lanes, advance model across the posedge
    task automatic cycle(input bit pva, input logic [7:0] pda, input bit pvb, input logic [7:0] pdb);
        bit rdy, vld, xfer, push, fb;
        rdy = m_ready();
        vld = (mq.size() > 0);
        chk("b_put_ready", 32'(b_put_ready), 32'(mq.size() < DEPTH));
        chk("b_valid", 32'(b_valid), 32'(vld));
        if (vld) chk("b_data", 32'(b_data), 32'(mq[0]));
        chk("b_ready", 32'(b_ready), 32'(rdy));
        chk("b_rx_valid", 32'(b_rx_valid), 32'(m_rxv));
        if (m_rxv) chk("b_rx_data", 32'(b_rx_data), 32'(m_rxd));
        chk("b_beat_count", 32'(b_beat_count), 32'(m_cnt));
        if (prev_vld && !prev_rdy) begin
            chk("b_hold_valid", 32'(b_valid), 32'd1);
            chk("b_hold_data", 32'(b_data), 32'(prev_dat));
        end
        if (m_live) begin
            low_run = b_ready ? 0 : low_run + 1;
            chk("b_low_run_le3", 32'(low_run <= 3), 32'd1);
        end
        if (!b_put_ready) saw_full = 1;
        prev_vld = b_valid; prev_rdy = b_ready; prev_dat = b_data;
        if (b_rx_valid) obs.push_back(b_rx_data);
        a_put_valid = pva; a_put_data = pda;
        b_put_valid = pvb; b_put_data = pdb;
        @(posedge clk);
        xfer = vld && rdy;
        push = pvb && (mq.size() < DEPTH);
        m_rxv = xfer;
        if (xfer) begin
            m_rxd = mq.pop_front();
            m_cnt = m_cnt + 16'd1;
        end
        if (push) mq.push_back(pdb);
        if (m_live) begin
            m_stall = rdy ? 0 : m_stall + 1;
            fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = {fb, m_lfsr[15:1]};
        end
        m_live = 1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic offer_b(input bit pv, input logic [7:0] d);
        if (pv && mq.size() < DEPTH) eq.push_back(d);
        cycle(1'b0, 8'h00, pv, d);
    endtask

    task automatic put_b(input logic [7:0] d);
        bit acc;
        acc = 0;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = (mq.size() < DEPTH);
            offer_b(1'b1, d);
        end
        chk("b_put_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain_b();
        for (int t = 0; t < 100; t++) begin
            if (mq.size() == 0 && !m_rxv) break;
            idle(1);
        end
        chk("b_drained", 32'(mq.size()), 32'd0);
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, 32'(obs.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size(); i++) begin
            if (i < obs.size()) chk({name, "_beat"}, 32'(obs[i]), 32'(eq[i]));
        end
    endtask

    typedef struct {
        logic        pv;
        logic [7:0]  pd;
        logic        e_prdy;
        logic        e_vld;
        logic [7:0]  e_dat;
        logic        e_rdy;
        logic        e_rxv;
        logic [7:0]  e_rxd;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] dir  [8];

    initial begin
        bit   done;
        int   tally, sent, idx, bad;
        logic [7:0] lst [4];

        vecs[0] = '{1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'd0};
        vecs[1] = '{1'b1, 8'hB2, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 16'd0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b1, 8'hA1, 16'd1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 16'd2};
        vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'd2};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h00, 16'd2};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 16'd3};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'd3};
        dir = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hAB, 8'hCD, 8'hEF, 8'h12};
        lst = '{8'hAB, 8'hCD, 8'hEF, 8'h12};

        a_put_valid = 0; a_put_data = 0; b_put_valid = 0; b_put_data = 0;
        saw_full = 0;
        m_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_a_data", 32'(a_data), 32'd0);
        chk("rst_a_rx_valid", 32'(a_rx_valid), 32'd0);
        chk("rst_a_rx_data", 32'(a_rx_data), 32'd0);
        chk("rst_a_count", 32'(a_beat_count), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_b_data", 32'(b_data), 32'd0);
        chk("rst_b_rx_valid", 32'(b_rx_valid), 32'd0);
        chk("rst_b_rx_data", 32'(b_rx_data), 32'd0);
        chk("rst_b_count", 32'(b_beat_count), 32'd0);
        #7 rst = 1'b1;

        while ($time < 500) idle(1);

        // Lane a: back-to-back puts, then an isolated beat
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("a_vec%0d_put_ready", k), 32'(a_put_ready), 32'(vecs[k].e_prdy));
            chk($sformatf("a_vec%0d_valid", k), 32'(a_valid), 32'(vecs[k].e_vld));
            if (vecs[k].e_vld) chk($sformatf("a_vec%0d_data", k), 32'(a_data), 32'(vecs[k].e_dat));
            chk($sformatf("a_vec%0d_ready", k), 32'(a_ready), 32'(vecs[k].e_rdy));
            chk($sformatf("a_vec%0d_rx_valid", k), 32'(a_rx_valid), 32'(vecs[k].e_rxv));
            if (vecs[k].e_rxv) chk($sformatf("a_vec%0d_rx_data", k), 32'(a_rx_data), 32'(vecs[k].e_rxd));
            chk($sformatf("a_vec%0d_count", k), 32'(a_beat_count), 32'(vecs[k].e_cnt));
            cycle(vecs[k].pv, vecs[k].pd, 1'b0, 8'h00);
        end

        // Lane b: gapped sequence under LFSR backpressure
        obs.delete(); eq.delete();
        put_b(8'hA1); put_b(8'hB2); idle(10);
        put_b(8'hC3); idle(4);
        put_b(8'hD4); idle(10);
        put_b(8'hAB); put_b(8'hCD); put_b(8'hEF); put_b(8'h12);
        drain_b();
        chk("b_dir_len", 32'(obs.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs.size()) chk("b_dir_beat", 32'(obs[i]), 32'(dir[i]));
        end
        chk("b_dir_count", 32'(b_beat_count), 32'd8);

        // Lane b: offer every cycle until full, then two more offers while full
        obs.delete(); eq.delete(); saw_full = 0; idx = 0;
        for (int i = 0; i < 60 && idx < 2; i++) begin
            if (mq.size() == DEPTH) idx++;
            offer_b(1'b1, 8'h50 + 8'(i));
        end
        drain_b();
        chk("b_saw_full", 32'(saw_full), 32'd1);
        cmp_stream("b_full");

        // Lane b: reset right after CD is accepted
        obs.delete(); idx = 0; done = 0;
        for (int t = 0; t < 80 && !done; t++) begin
            if (m_rxv && m_rxd == 8'hCD) done = 1;
            else begin
                offer_b(idx < 4, (idx < 4) ? lst[idx] : 8'h00);
                if (idx < 4 && eq.size() > 0 && eq[eq.size()-1] == lst[idx]) idx++;
            end
        end
        chk("b_cd_seen", 32'(done), 32'd1);
        chk("b_cd_rx_valid", 32'(b_rx_valid), 32'd1);
        chk("b_cd_rx_data", 32'(b_rx_data), 32'hCD);
        rst = 1'b0;
        #1;
        chk("b_mid_rst_valid", 32'(b_valid), 32'd0);
        chk("b_mid_rst_ready", 32'(b_ready), 32'd0);
        chk("b_mid_rst_rx_valid", 32'(b_rx_valid), 32'd0);
        chk("b_mid_rst_count", 32'(b_beat_count), 32'd0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        obs.delete();
        idle(20);
        bad = 0;
        foreach (obs[i]) if (obs[i] == 8'hEF || obs[i] == 8'h12) bad++;
        chk("b_no_ef_12_after_rst", 32'(bad + obs.size()), 32'd0);
        chk("b_post_rst_count", 32'(b_beat_count), 32'd0);

        // Lane b: randomized offers at varying intensity
        obs.delete(); eq.delete();
        for (int seg = 0; seg < 5; seg++) begin
            int thresh;
            thresh = 20 + 20 * seg;
            for (int i = 0; i < 300; i++) begin
                offer_b($urandom_range(0, 99) < thresh, 8'($urandom_range(0, 255)));
            end
        end
        drain_b();
        cmp_stream("b_rand");

        // Lane a: 65536 beats wrap beat_count back to zero
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        tally = 0; sent = 0; done = 0;
        for (int t = 0; t < 65800 && !done; t++) begin
            if (a_rx_valid) begin
                chk("a_wrap_data", 32'(a_rx_data), 32'(tally[7:0]));
                tally++;
                if (tally == 65535) chk("a_count_ffff", 32'(a_beat_count), 32'hFFFF);
                if (tally == 65536) begin
                    chk("a_count_wrap", 32'(a_beat_count), 32'd0);
                    done = 1;
                end
            end
            if (sent < 65536) begin
                a_put_valid = 1'b1;
                a_put_data  = sent[7:0];
                if (a_put_ready) sent++;
            end else begin
                a_put_valid = 1'b0;
            end
            @(negedge clk);
        end
        if (!done) chk("a_wrap_done", 32'(tally), 32'd65536);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
